// File: rtl/ball_motion_ctrl_if.sv
// Signal bundle between the pong ball engine and the rest of the core:
// frame/serve/bat-hit strobes and speed/angle selects in, ball state and
// sound/score pulses out.
interface ball_motion_ctrl_if;
   logic       i_frame;
   logic       i_speed;
   logic       i_angle;
   logic       i_hit_l;
   logic       i_hit_r;
   logic [1:0] i_zone;
   logic       i_serve;
   logic [8:0] o_ball_x;
   logic [7:0] o_ball_y;
   logic       o_dir_x;
   logic       o_dir_y;
   logic       o_ball_on;
   logic       o_sound;
   logic       o_score_l;
   logic       o_score_r;

   // Driver side: supplies strobes and selects, observes the ball
   modport master (
      output i_frame, i_speed, i_angle, i_hit_l, i_hit_r, i_zone, i_serve,
      input  o_ball_x, o_ball_y, o_dir_x, o_dir_y, o_ball_on, o_sound,
             o_score_l, o_score_r
   );

   // Engine side
   modport slave (
      input  i_frame, i_speed, i_angle, i_hit_l, i_hit_r, i_zone, i_serve,
      output o_ball_x, o_ball_y, o_dir_x, o_dir_y, o_ball_on, o_sound,
             o_score_l, o_score_r
   );
endinterface

// File: rtl/ball_motion_ctrl.sv
// Ball position/direction engine for the AY-3-8500 pong core.
// Advances the ball once per video frame, reflects it off the top/bottom
// walls and the bats, detects goals, and generates the rebound sound pulse
// and the score pulses. All outputs come straight from flops.
//
// Build option: define AUTO_SERVE_EN to let the SERVE state launch the ball
// by itself after SERVE_DELAY frames, aimed at the player who just conceded.
// Without it, SERVE waits for i_serve indefinitely.
module ball_motion_ctrl #(
   parameter logic [8:0]  XMAX        = 9'd255,
   parameter logic [7:0]  YMAX        = 8'd223,
   parameter int          SLOW_DX     = 2,
   parameter int          FAST_DX     = 4,
   parameter int          SHALLOW_DY  = 1,
   parameter int          STEEP_DY    = 2,
   parameter logic [15:0] SOUND_LEN   = 16'd4096,
   parameter logic [5:0]  SERVE_DELAY = 6'd60
) (
   input logic               i_clk,
   input logic               i_rst_n,
   ball_motion_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      ST_SERVE = 2'd0,
      ST_PLAY  = 2'd1,
      ST_OUT   = 2'd2
   } state_t;

   localparam logic [8:0] X_CENTRE = XMAX >> 1;
   localparam logic [7:0] Y_CENTRE = YMAX >> 1;

   state_t      state_q, state_d;
   logic [8:0]  x_q, x_d;
   logic [7:0]  y_q, y_d;
   logic        dir_x_q, dir_x_d;
   logic        dir_y_q, dir_y_d;
   logic        spd_q, spd_d;
   logic        ang_q, ang_d;
   logic [5:0]  frm_q, frm_d;
   logic [15:0] snd_cnt_q, snd_cnt_d;
   logic        snd_pend_q, snd_pend_d;
   logic        sound_q, sound_d;
   logic        ball_on_q, ball_on_d;
   logic        score_l_q, score_l_d;
   logic        score_r_q, score_r_d;
`ifdef AUTO_SERVE_EN
   logic        concede_r_q, concede_r_d;
`endif

   logic              hit_l_ok, hit_r_ok, hit_ok;
   logic              eff_dir_x, eff_dir_y, eff_spd, eff_ang;
   logic signed [9:0] xs, ys, step_dx, step_dy, nx, ny;
   logic signed [9:0] xmax_s, ymax_s;
   logic              wall_top, wall_bot, goal_left, goal_right;
   logic              snd_trig;

   // State register: everything the engine remembers, reset to a centred serve
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= ST_SERVE;
         x_q         <= X_CENTRE;
         y_q         <= Y_CENTRE;
         dir_x_q     <= 1'b1;
         dir_y_q     <= 1'b0;
         spd_q       <= 1'b0;
         ang_q       <= 1'b0;
         frm_q       <= '0;
         snd_cnt_q   <= '0;
         snd_pend_q  <= 1'b0;
         sound_q     <= 1'b0;
         ball_on_q   <= 1'b0;
         score_l_q   <= 1'b0;
         score_r_q   <= 1'b0;
`ifdef AUTO_SERVE_EN
         concede_r_q <= 1'b1;
`endif
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         y_q         <= y_d;
         dir_x_q     <= dir_x_d;
         dir_y_q     <= dir_y_d;
         spd_q       <= spd_d;
         ang_q       <= ang_d;
         frm_q       <= frm_d;
         snd_cnt_q   <= snd_cnt_d;
         snd_pend_q  <= snd_pend_d;
         sound_q     <= sound_d;
         ball_on_q   <= ball_on_d;
         score_l_q   <= score_l_d;
         score_r_q   <= score_r_d;
`ifdef AUTO_SERVE_EN
         concede_r_q <= concede_r_d;
`endif
      end
   end

   // Next-state logic: bat reflection first, then the frame step using the
   // post-hit direction and speed/angle, then wall/goal resolution and sound
   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      y_d         = y_q;
      dir_x_d     = dir_x_q;
      dir_y_d     = dir_y_q;
      spd_d       = spd_q;
      ang_d       = ang_q;
      frm_d       = frm_q;
      ball_on_d   = ball_on_q;
      score_l_d   = 1'b0;
      score_r_d   = 1'b0;
      snd_trig    = 1'b0;
      snd_cnt_d   = snd_cnt_q;
      snd_pend_d  = 1'b0;
`ifdef AUTO_SERVE_EN
      concede_r_d = concede_r_q;
`endif

      // A bat only reflects a ball travelling towards it; simultaneous hits
      // on both bats are treated as noise and ignored.
      hit_l_ok  = bus.i_hit_l & ~bus.i_hit_r & ~dir_x_q;
      hit_r_ok  = bus.i_hit_r & ~bus.i_hit_l &  dir_x_q;
      hit_ok    = (state_q == ST_PLAY) & (hit_l_ok | hit_r_ok);

      eff_dir_x = hit_ok ? ~dir_x_q : dir_x_q;
      eff_dir_y = dir_y_q;
      if (hit_ok) begin
         if (bus.i_zone == 2'd0)
            eff_dir_y = 1'b0;
         else if (bus.i_zone == 2'd2)
            eff_dir_y = 1'b1;
      end
      eff_spd   = hit_ok ? bus.i_speed : spd_q;
      eff_ang   = hit_ok ? bus.i_angle : ang_q;

      step_dx   = eff_spd ? 10'(FAST_DX) : 10'(SLOW_DX);
      step_dy   = eff_ang ? 10'(STEEP_DY) : 10'(SHALLOW_DY);
      xs        = $signed({1'b0, x_q});
      ys        = $signed({2'b00, y_q});
      xmax_s    = $signed({1'b0, XMAX});
      ymax_s    = $signed({2'b00, YMAX});
      nx        = eff_dir_x ? (xs + step_dx) : (xs - step_dx);
      ny        = eff_dir_y ? (ys + step_dy) : (ys - step_dy);

      wall_top   = (ny < 10'sd0);
      wall_bot   = (ny > ymax_s);
      goal_right = (nx < 10'sd0);
      goal_left  = (nx > xmax_s);

      case (state_q)
         ST_SERVE: begin
            x_d = X_CENTRE;
            y_d = Y_CENTRE;
            if (bus.i_serve) begin
               state_d   = ST_PLAY;
               spd_d     = bus.i_speed;
               ang_d     = bus.i_angle;
               ball_on_d = 1'b1;
               frm_d     = '0;
            end
`ifdef AUTO_SERVE_EN
            else if (bus.i_frame) begin
               if (frm_q == SERVE_DELAY - 6'd1) begin
                  state_d   = ST_PLAY;
                  spd_d     = bus.i_speed;
                  ang_d     = bus.i_angle;
                  dir_x_d   = concede_r_q;
                  ball_on_d = 1'b1;
                  frm_d     = '0;
               end else begin
                  frm_d = frm_q + 6'd1;
               end
            end
`endif
         end

         ST_PLAY: begin
            dir_x_d  = eff_dir_x;
            dir_y_d  = eff_dir_y;
            spd_d    = eff_spd;
            ang_d    = eff_ang;
            snd_trig = hit_ok;
            if (bus.i_frame) begin
               x_d = nx[8:0];
               y_d = ny[7:0];
               if (wall_top) begin
                  y_d      = 8'd0;
                  dir_y_d  = 1'b1;
                  snd_trig = 1'b1;
               end else if (wall_bot) begin
                  y_d      = YMAX;
                  dir_y_d  = 1'b0;
                  snd_trig = 1'b1;
               end
               if (goal_right) begin
                  x_d         = 9'd0;
                  score_r_d   = 1'b1;
                  state_d     = ST_OUT;
                  ball_on_d   = 1'b0;
                  frm_d       = '0;
                  snd_trig    = 1'b0;
`ifdef AUTO_SERVE_EN
                  concede_r_d = 1'b0;
`endif
               end else if (goal_left) begin
                  x_d         = XMAX;
                  score_l_d   = 1'b1;
                  state_d     = ST_OUT;
                  ball_on_d   = 1'b0;
                  frm_d       = '0;
                  snd_trig    = 1'b0;
`ifdef AUTO_SERVE_EN
                  concede_r_d = 1'b1;
`endif
               end
            end
         end

         ST_OUT: begin
            if (bus.i_frame) begin
               if (frm_q == SERVE_DELAY - 6'd1) begin
                  state_d = ST_SERVE;
                  frm_d   = '0;
                  x_d     = X_CENTRE;
                  y_d     = Y_CENTRE;
               end else begin
                  frm_d = frm_q + 6'd1;
               end
            end
         end

         default: state_d = ST_SERVE;
      endcase

      // A retrigger while the pulse is running drops the output for one
      // clock before reloading, so every rebound yields a fresh rising edge.
      if (snd_pend_q) begin
         snd_cnt_d = SOUND_LEN;
      end else if (snd_trig) begin
         if (snd_cnt_q != 16'd0) begin
            snd_cnt_d  = 16'd0;
            snd_pend_d = 1'b1;
         end else begin
            snd_cnt_d = SOUND_LEN;
         end
      end else if (snd_cnt_q != 16'd0) begin
         snd_cnt_d = snd_cnt_q - 16'd1;
      end
      sound_d = (snd_cnt_d != 16'd0);
   end

   assign bus.o_ball_x  = x_q;
   assign bus.o_ball_y  = y_q;
   assign bus.o_dir_x   = dir_x_q;
   assign bus.o_dir_y   = dir_y_q;
   assign bus.o_ball_on = ball_on_q;
   assign bus.o_sound   = sound_q;
   assign bus.o_score_l = score_l_q;
   assign bus.o_score_r = score_r_q;

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Directed testbench for ball_motion_ctrl. Inputs change on the falling
// edge, outputs are sampled on the falling edge after the active edge.
module tb_ball_motion_ctrl;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   ball_motion_ctrl_if bus();

   ball_motion_ctrl dut (
      .i_clk  (clk),
      .i_rst_n(rst_n),
      .bus    (bus.slave)
   );

   // Hard time limit so a stuck design still produces a verdict
   initial begin
      #3_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic apply_reset;
      rst_n       = 1'b0;
      bus.i_frame = 1'b0;
      bus.i_speed = 1'b0;
      bus.i_angle = 1'b0;
      bus.i_hit_l = 1'b0;
      bus.i_hit_r = 1'b0;
      bus.i_zone  = 2'd0;
      bus.i_serve = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic run_frames(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         bus.i_frame = 1'b1;
         @(negedge clk);
         bus.i_frame = 1'b0;
      end
   endtask

   task automatic do_serve(input logic spd, input logic ang);
      @(negedge clk);
      bus.i_speed = spd;
      bus.i_angle = ang;
      bus.i_serve = 1'b1;
      @(negedge clk);
      bus.i_serve = 1'b0;
   endtask

   task automatic do_hit(input logic l, input logic r, input logic [1:0] z,
                         input logic spd, input logic ang, input logic frm);
      @(negedge clk);
      bus.i_hit_l = l;
      bus.i_hit_r = r;
      bus.i_zone  = z;
      bus.i_speed = spd;
      bus.i_angle = ang;
      bus.i_frame = frm;
      @(negedge clk);
      bus.i_hit_l = 1'b0;
      bus.i_hit_r = 1'b0;
      bus.i_frame = 1'b0;
   endtask

   task automatic measure_sound(output int w);
      w = 0;
      while (bus.o_sound === 1'b1 && w < 5000) begin
         w++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      apply_reset();
      n_cmp++; if (bus.o_ball_x !== 9'd127) begin n_bad++; $display("[TB] FAIL reset_x: got %0d want 127", bus.o_ball_x); end
      n_cmp++; if (bus.o_ball_y !== 8'd111) begin n_bad++; $display("[TB] FAIL reset_y: got %0d want 111", bus.o_ball_y); end
      n_cmp++; if (bus.o_dir_x !== 1'b1) begin n_bad++; $display("[TB] FAIL reset_dir_x: got %b want 1", bus.o_dir_x); end
      n_cmp++; if (bus.o_dir_y !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_dir_y: got %b want 0", bus.o_dir_y); end
      n_cmp++; if (bus.o_ball_on !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_ball_on: got %b want 0", bus.o_ball_on); end
      n_cmp++; if (bus.o_sound !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_sound: got %b want 0", bus.o_sound); end
      n_cmp++; if ({bus.o_score_l, bus.o_score_r} !== 2'b00) begin n_bad++; $display("[TB] FAIL reset_scores: got %b%b want 00", bus.o_score_l, bus.o_score_r); end
   endtask

   task automatic test_serve_step;
      apply_reset();
      do_serve(1'b0, 1'b0);
      n_cmp++; if (bus.o_ball_on !== 1'b1) begin n_bad++; $display("[TB] FAIL serve_ball_on: got %b want 1", bus.o_ball_on); end
      n_cmp++; if (bus.o_ball_x !== 9'd127) begin n_bad++; $display("[TB] FAIL serve_x: got %0d want 127", bus.o_ball_x); end
      run_frames(1);
      n_cmp++; if (bus.o_ball_x !== 9'd129) begin n_bad++; $display("[TB] FAIL step1_x: got %0d want 129", bus.o_ball_x); end
      n_cmp++; if (bus.o_ball_y !== 8'd110) begin n_bad++; $display("[TB] FAIL step1_y: got %0d want 110", bus.o_ball_y); end
      run_frames(9);
      n_cmp++; if (bus.o_ball_x !== 9'd147) begin n_bad++; $display("[TB] FAIL step10_x: got %0d want 147", bus.o_ball_x); end
      n_cmp++; if (bus.o_ball_y !== 8'd101) begin n_bad++; $display("[TB] FAIL step10_y: got %0d want 101", bus.o_ball_y); end
   endtask

   task automatic test_wall;
      int w;
      apply_reset();
      do_serve(1'b0, 1'b1);
      run_frames(55);
      n_cmp++; if (bus.o_ball_y !== 8'd1) begin n_bad++; $display("[TB] FAIL wall_pre_y: got %0d want 1", bus.o_ball_y); end
      n_cmp++; if (bus.o_ball_x !== 9'd237) begin n_bad++; $display("[TB] FAIL wall_pre_x: got %0d want 237", bus.o_ball_x); end
      n_cmp++; if (bus.o_sound !== 1'b0) begin n_bad++; $display("[TB] FAIL wall_pre_sound: got %b want 0", bus.o_sound); end
      run_frames(1);
      n_cmp++; if (bus.o_ball_y !== 8'd0) begin n_bad++; $display("[TB] FAIL wall_y: got %0d want 0", bus.o_ball_y); end
      n_cmp++; if (bus.o_dir_y !== 1'b1) begin n_bad++; $display("[TB] FAIL wall_dir_y: got %b want 1", bus.o_dir_y); end
      n_cmp++; if (bus.o_ball_x !== 9'd239) begin n_bad++; $display("[TB] FAIL wall_x: got %0d want 239", bus.o_ball_x); end
      measure_sound(w);
      n_cmp++; if (w != 4096) begin n_bad++; $display("[TB] FAIL wall_sound_len: got %0d want 4096", w); end
   endtask

   task automatic test_bat_hit;
      apply_reset();
      do_serve(1'b0, 1'b0);
      run_frames(2);
      n_cmp++; if (bus.o_ball_x !== 9'd131) begin n_bad++; $display("[TB] FAIL bat_pre_x: got %0d want 131", bus.o_ball_x); end
      do_hit(1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0);
      n_cmp++; if ({bus.o_dir_x, bus.o_dir_y} !== 2'b01) begin n_bad++; $display("[TB] FAIL hit_r_z2_dirs: got %b%b want 01", bus.o_dir_x, bus.o_dir_y); end
      run_frames(1);
      n_cmp++; if (bus.o_ball_x !== 9'd127) begin n_bad++; $display("[TB] FAIL hit_r_step_x: got %0d want 127", bus.o_ball_x); end
      n_cmp++; if (bus.o_ball_y !== 8'd110) begin n_bad++; $display("[TB] FAIL hit_r_step_y: got %0d want 110", bus.o_ball_y); end
      do_hit(1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
      n_cmp++; if ({bus.o_dir_x, bus.o_dir_y} !== 2'b01) begin n_bad++; $display("[TB] FAIL both_hits_ignored: got %b%b want 01", bus.o_dir_x, bus.o_dir_y); end
      do_hit(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
      n_cmp++; if ({bus.o_dir_x, bus.o_dir_y} !== 2'b01) begin n_bad++; $display("[TB] FAIL wrong_side_ignored: got %b%b want 01", bus.o_dir_x, bus.o_dir_y); end
      do_hit(1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1);
      n_cmp++; if ({bus.o_dir_x, bus.o_dir_y} !== 2'b10) begin n_bad++; $display("[TB] FAIL hit_frame_dirs: got %b%b want 10", bus.o_dir_x, bus.o_dir_y); end
      n_cmp++; if (bus.o_ball_x !== 9'd129) begin n_bad++; $display("[TB] FAIL hit_frame_x: got %0d want 129", bus.o_ball_x); end
      n_cmp++; if (bus.o_ball_y !== 8'd108) begin n_bad++; $display("[TB] FAIL hit_frame_y: got %0d want 108", bus.o_ball_y); end
      do_hit(1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0);
      n_cmp++; if ({bus.o_dir_x, bus.o_dir_y} !== 2'b00) begin n_bad++; $display("[TB] FAIL centre_dirs: got %b%b want 00", bus.o_dir_x, bus.o_dir_y); end
      run_frames(1);
      n_cmp++; if (bus.o_ball_x !== 9'd125) begin n_bad++; $display("[TB] FAIL centre_step_x: got %0d want 125", bus.o_ball_x); end
      n_cmp++; if (bus.o_ball_y !== 8'd107) begin n_bad++; $display("[TB] FAIL centre_step_y: got %0d want 107", bus.o_ball_y); end
   endtask

   task automatic test_goal_right;
      apply_reset();
      do_serve(1'b1, 1'b0);
      run_frames(32);
      n_cmp++; if (bus.o_ball_x !== 9'd255) begin n_bad++; $display("[TB] FAIL edge_x: got %0d want 255", bus.o_ball_x); end
      n_cmp++; if ({bus.o_ball_on, bus.o_score_l} !== 2'b10) begin n_bad++; $display("[TB] FAIL edge_no_goal: got on=%b score_l=%b want on=1 score_l=0", bus.o_ball_on, bus.o_score_l); end
      run_frames(1);
      n_cmp++; if (bus.o_score_l !== 1'b1) begin n_bad++; $display("[TB] FAIL goal_score_l: got %b want 1", bus.o_score_l); end
      n_cmp++; if (bus.o_ball_x !== 9'd255) begin n_bad++; $display("[TB] FAIL goal_x_clamp: got %0d want 255", bus.o_ball_x); end
      n_cmp++; if (bus.o_ball_on !== 1'b0) begin n_bad++; $display("[TB] FAIL goal_ball_on: got %b want 0", bus.o_ball_on); end
      @(negedge clk);
      n_cmp++; if (bus.o_score_l !== 1'b0) begin n_bad++; $display("[TB] FAIL goal_pulse_width: got %b want 0", bus.o_score_l); end
      run_frames(59);
      n_cmp++; if (bus.o_ball_x !== 9'd255) begin n_bad++; $display("[TB] FAIL out_59_x: got %0d want 255", bus.o_ball_x); end
      do_serve(1'b0, 1'b0);
      n_cmp++; if (bus.o_ball_on !== 1'b0) begin n_bad++; $display("[TB] FAIL out_serve_ignored: got %b want 0", bus.o_ball_on); end
      run_frames(1);
      n_cmp++; if ({bus.o_ball_x, bus.o_ball_y} !== {9'd127, 8'd111}) begin n_bad++; $display("[TB] FAIL out_60_centre: got x=%0d y=%0d want x=127 y=111", bus.o_ball_x, bus.o_ball_y); end
      do_serve(1'b0, 1'b0);
      n_cmp++; if (bus.o_ball_on !== 1'b1) begin n_bad++; $display("[TB] FAIL reserve_ball_on: got %b want 1", bus.o_ball_on); end
   endtask

   task automatic test_goal_left;
      apply_reset();
      do_serve(1'b1, 1'b0);
      do_hit(1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0);
      run_frames(31);
      n_cmp++; if (bus.o_ball_x !== 9'd3) begin n_bad++; $display("[TB] FAIL left_pre_x: got %0d want 3", bus.o_ball_x); end
      run_frames(1);
      n_cmp++; if ({bus.o_score_r, bus.o_score_l} !== 2'b10) begin n_bad++; $display("[TB] FAIL left_scores: got r=%b l=%b want r=1 l=0", bus.o_score_r, bus.o_score_l); end
      n_cmp++; if (bus.o_ball_x !== 9'd0) begin n_bad++; $display("[TB] FAIL left_x_clamp: got %0d want 0", bus.o_ball_x); end
      n_cmp++; if (bus.o_ball_on !== 1'b0) begin n_bad++; $display("[TB] FAIL left_ball_on: got %b want 0", bus.o_ball_on); end
   endtask

   task automatic test_retrigger;
      int w;
      apply_reset();
      do_serve(1'b0, 1'b1);
      run_frames(56);
      n_cmp++; if (bus.o_sound !== 1'b1) begin n_bad++; $display("[TB] FAIL retrig_first: got %b want 1", bus.o_sound); end
      repeat (100) @(negedge clk);
      do_hit(1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0);
      n_cmp++; if (bus.o_sound !== 1'b0) begin n_bad++; $display("[TB] FAIL retrig_gap: got %b want 0", bus.o_sound); end
      @(negedge clk);
      n_cmp++; if (bus.o_sound !== 1'b1) begin n_bad++; $display("[TB] FAIL retrig_rise: got %b want 1", bus.o_sound); end
      measure_sound(w);
      n_cmp++; if (w != 4096) begin n_bad++; $display("[TB] FAIL retrig_len: got %0d want 4096", w); end
      do_hit(1'b1, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0);
      n_cmp++; if (bus.o_sound !== 1'b1) begin n_bad++; $display("[TB] FAIL idle_trigger: got %b want 1", bus.o_sound); end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (bus.o_sound !== 1'b0) begin n_bad++; $display("[TB] FAIL async_reset_sound: got %b want 0", bus.o_sound); end
      n_cmp++; if ({bus.o_ball_on, bus.o_ball_x} !== {1'b0, 9'd127}) begin n_bad++; $display("[TB] FAIL async_reset_ball: got on=%b x=%0d want on=0 x=127", bus.o_ball_on, bus.o_ball_x); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_auto_serve;
      apply_reset();
`ifdef AUTO_SERVE_EN
      run_frames(59);
      n_cmp++; if (bus.o_ball_on !== 1'b0) begin n_bad++; $display("[TB] FAIL auto_59: got %b want 0", bus.o_ball_on); end
      run_frames(1);
      n_cmp++; if ({bus.o_ball_on, bus.o_dir_x} !== 2'b11) begin n_bad++; $display("[TB] FAIL auto_60: got on=%b dir_x=%b want 11", bus.o_ball_on, bus.o_dir_x); end
      run_frames(1);
      n_cmp++; if (bus.o_ball_x !== 9'd129) begin n_bad++; $display("[TB] FAIL auto_step_x: got %0d want 129", bus.o_ball_x); end
`else
      run_frames(200);
      n_cmp++; if (bus.o_ball_on !== 1'b0) begin n_bad++; $display("[TB] FAIL no_auto_ball_on: got %b want 0", bus.o_ball_on); end
      n_cmp++; if ({bus.o_ball_x, bus.o_dir_x} !== {9'd127, 1'b1}) begin n_bad++; $display("[TB] FAIL no_auto_hold: got x=%0d dir_x=%b want x=127 dir_x=1", bus.o_ball_x, bus.o_dir_x); end
`endif
   endtask

   initial begin
      test_reset();
      test_serve_step();
      test_wall();
      test_bat_hit();
      test_goal_right();
      test_goal_left();
      test_retrigger();
      test_auto_serve();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
